conv_window_scheduler: RTL

Frame-level sequencer for the convolution datapath. On start it sweeps every valid KxK window position over an IMG_W x IMG_H input feature map. For each window it issues K*K tap requests, each carrying a pixel address and a weight index, to the MAC unit over a valid/ready handshake. It then waits for the MAC to finish that window before moving on. It sits between the top-level control FSM and the line-buffer/MAC datapath, and replaces free-running coordinate counters with a back-pressurable scheduler.

---
 rtl/conv_window_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler: walks every KxK window of the frame
// and issues one tap per cycle to the MAC over a valid/ready handshake.
module conv_window_scheduler #(
  parameter int IMG_W = 10,
  parameter int IMG_H = 8,
  parameter int K     = 3,
  parameter int AW    = 7,
  parameter int WW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic [AW-1:0] pix_addr,
  output logic [WW-1:0] wgt_idx,
  output logic          first_tap,
  output logic          last_tap,
  input  logic          mac_done,
  output logic [6:0]    out_col,
  output logic [6:0]    out_row,
  output logic          busy,
  output logic          done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] kc_q, kc_d;
  logic [KW-1:0] kr_q, kr_d;
  logic [6:0]    col_q, col_d;
  logic [6:0]    row_q, row_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic kc_end, kr_end, col_end, row_end;

  assign kc_end  = (32'(kc_q) == K - 1);
  assign kr_end  = (32'(kr_q) == K - 1);
  assign col_end = (32'(col_q) == OUT_W - 1);
  assign row_end = (32'(row_q) == OUT_H - 1);

  assign tap_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_col   = col_q;
  assign out_row   = row_q;

  // Tap address and weight index derived from the registered counters
  assign pix_addr = AW'((32'(row_q) + 32'(kr_q)) * IMG_W
                        + 32'(col_q) + 32'(kc_q));
  assign wgt_idx  = WW'(32'(kr_q) * K + 32'(kc_q));
  assign first_tap = valid_q & (kc_q == '0) & (kr_q == '0);
  assign last_tap  = valid_q & kc_end & kr_end;

  // Next-state and counter update for the window sweep
  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          kc_d    = '0;
          kr_d    = '0;
          col_d   = '0;
          row_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        if (tap_ready) begin
          if (!kc_end) begin
            kc_d = kc_q + KW'(1);
          end else if (!kr_end) begin
            kc_d = '0;
            kr_d = kr_q + KW'(1);
          end else begin
            kc_d    = '0;
            kr_d    = '0;
            valid_d = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mac_done) begin
          if (!col_end) begin
            col_d   = col_q + 7'd1;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else if (!row_end) begin
            col_d   = '0;
            row_d   = row_q + 7'd1;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kc_q    <= '0;
      kr_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      kr_q    <= kr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
